// File: rtl/onewire_pkg.sv
// rtl/onewire_pkg.sv - shared command encodings, FSM states and counter width for the 1-Wire byte engine
package onewire_pkg;

    typedef enum logic [1:0] {
        CMD_RESET = 2'b00,
        CMD_WRITE = 2'b01,
        CMD_READ  = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        RST_LOW,
        RST_WAIT,
        SLOT_LOW,
        SLOT_HOLD,
        SLOT_REC,
        DONE
    } state_e;

    localparam int CNT_W = 9;

endpackage

// File: rtl/onewire_if.sv
// rtl/onewire_if.sv - host-side command/result bundle of the 1-Wire byte engine
interface onewire_if;

    logic       start;
    logic [1:0] cmd;
    logic [7:0] tx_byte;
    logic [7:0] rx_byte;
    logic       EoB;
    logic       busy;
    logic       presence;

    modport master (
        output start, cmd, tx_byte,
        input  rx_byte, EoB, busy, presence
    );

    modport slave (
        input  start, cmd, tx_byte,
        output rx_byte, EoB, busy, presence
    );

endinterface

// File: rtl/onewire_slot_timer.sv
// rtl/onewire_slot_timer.sv - 1 MHz tick counter with clear and terminal-count compare
module onewire_slot_timer
    import onewire_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clr,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/onewire_byte_io.sv
// rtl/onewire_byte_io.sv - 1-Wire master: bus reset/presence, byte write, byte read (ONEWIRE_STRONG_PULLUP_EN adds spu)
module onewire_byte_io
    import onewire_pkg::*;
#(
    parameter int T_RSTL = 480,
    parameter int T_PDS  = 70,
    parameter int T_SLOT = 60,
    parameter int T_LOW  = 6,
    parameter int T_RDS  = 15,
    parameter int T_REC  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       F1M,
    onewire_if.slave   bus,
    input  logic       dq_in,
    output logic       dq_oe
`ifdef ONEWIRE_STRONG_PULLUP_EN
    ,
    output logic       spu
`endif
);

    localparam logic [CNT_W-1:0] RSTL_TC = CNT_W'(T_RSTL - 1);
    localparam logic [CNT_W-1:0] SLOT_TC = CNT_W'(T_SLOT - 1);
    localparam logic [CNT_W-1:0] LOW_TC  = CNT_W'(T_LOW - 1);
    localparam logic [CNT_W-1:0] REC_TC  = CNT_W'(T_REC - 1);
    localparam logic [CNT_W-1:0] PDS_PT  = CNT_W'(T_PDS);
    localparam logic [CNT_W-1:0] RDS_PT  = CNT_W'(T_RDS);

    state_e           state, state_d;
    cmd_e             cmd_q;
    cmd_e             cmd_in;
    logic [7:0]       shreg;
    logic [2:0]       bit_idx;
    logic [7:0]       byte_q;
    logic             presence_q;
    logic             accept;
    logic             clr;
    logic [CNT_W-1:0] term;
    logic [CNT_W-1:0] cnt;
    logic             tc;
    logic             step;
    logic             long_low;
    logic             sample_pt;

    assign cmd_in    = cmd_e'(bus.cmd);
    assign step      = F1M & tc;
    // A write-0 keeps the bus low for the whole slot; write-1 and read use the short pulse.
    assign long_low  = (cmd_q == CMD_WRITE) && !shreg[bit_idx];
    assign sample_pt = (state == SLOT_LOW || state == SLOT_HOLD) && (cnt == RDS_PT);

    onewire_slot_timer u_timer (
        .clk  (clk),
        .rst  (rst),
        .tick (F1M),
        .clr  (clr),
        .term (term),
        .cnt  (cnt),
        .tc   (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        clr     = 1'b0;
        term    = '0;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                clr = 1'b1;
                if (bus.start && cmd_in != CMD_RSVD) begin
                    accept  = 1'b1;
                    state_d = (cmd_in == CMD_RESET) ? RST_LOW : SLOT_LOW;
                end
            end
            RST_LOW: begin
                term = RSTL_TC;
                if (step) begin
                    state_d = RST_WAIT;
                    clr     = 1'b1;
                end
            end
            RST_WAIT: begin
                term = RSTL_TC;
                if (step) begin
                    state_d = IDLE;
                    clr     = 1'b1;
                end
            end
            SLOT_LOW: begin
                term = long_low ? SLOT_TC : LOW_TC;
                if (step) begin
                    // The counter keeps running into SLOT_HOLD so the slot totals T_SLOT ticks.
                    if (long_low) begin
                        state_d = SLOT_REC;
                        clr     = 1'b1;
                    end else begin
                        state_d = SLOT_HOLD;
                    end
                end
            end
            SLOT_HOLD: begin
                term = SLOT_TC;
                if (step) begin
                    state_d = SLOT_REC;
                    clr     = 1'b1;
                end
            end
            SLOT_REC: begin
                term = REC_TC;
                if (step) begin
                    state_d = (bit_idx == 3'd7) ? DONE : SLOT_LOW;
                    clr     = 1'b1;
                end
            end
            DONE: begin
                if (F1M) begin
                    state_d = IDLE;
                    clr     = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                clr     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q      <= CMD_RESET;
            shreg      <= 8'h00;
            bit_idx    <= 3'd0;
            byte_q     <= 8'h00;
            presence_q <= 1'b0;
        end else begin
            if (accept) begin
                cmd_q   <= cmd_in;
                shreg   <= (cmd_in == CMD_WRITE) ? bus.tx_byte : 8'h00;
                bit_idx <= 3'd0;
            end
            if (F1M && state == RST_WAIT && cnt == PDS_PT) begin
                presence_q <= ~dq_in;
            end
            if (F1M && sample_pt && cmd_q == CMD_READ) begin
                shreg[bit_idx] <= dq_in;
            end
            if (step && state == SLOT_REC) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (F1M && state == DONE) begin
                byte_q <= shreg;
            end
        end
    end

`ifdef ONEWIRE_STRONG_PULLUP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spu <= 1'b0;
        end else if (accept) begin
            spu <= 1'b0;
        end else if (F1M && state == DONE && cmd_q == CMD_WRITE) begin
            spu <= 1'b1;
        end
    end
`endif

    assign dq_oe        = (state == RST_LOW) || (state == SLOT_LOW);
    assign bus.busy     = (state != IDLE);
    assign bus.EoB      = (state == DONE) && F1M;
    assign bus.rx_byte  = byte_q;
    assign bus.presence = presence_q;

endmodule

// File: tb/tb_onewire_byte_io.sv
// tb/tb_onewire_byte_io.sv - randomized self-checking bench with bus/slave model for onewire_byte_io
module tb_onewire_byte_io;

    localparam int T_RSTL = 480;
    localparam int T_SLOT = 60;
    localparam int T_LOW  = 6;
    localparam int T_REC  = 2;
    localparam int BYTE_TICKS = 8 * (T_SLOT + T_REC) + 1;

    logic clk;
    logic rst;
    logic F1M;
    logic dq_oe;
    logic slv_pull = 1'b0;
    wire  dq_in = ~(dq_oe | slv_pull);
`ifdef ONEWIRE_STRONG_PULLUP_EN
    logic spu;
`endif

    onewire_if bus_if ();

    onewire_byte_io dut (
        .clk   (clk),
        .rst   (rst),
        .F1M   (F1M),
        .bus   (bus_if),
        .dq_in (dq_in),
        .dq_oe (dq_oe)
`ifdef ONEWIRE_STRONG_PULLUP_EN
        ,
        .spu   (spu)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // bus observers and slave device state
    int   low_q[$];
    int   low_cnt    = 0;
    int   op_ticks   = 0;
    int   busy_ticks = 0;
    int   eob_cnt    = 0;
    int   eob_at     = 0;
    logic eob_f1m    = 1'b0;
    int   slv_mode   = 0;
    logic [7:0] slv_data = 8'h00;
    int   slv_cnt    = 0;
    int   slv_bit    = 0;
    bit   slv_pres   = 0;
    logic prev_oe    = 1'b0;
    logic prev_busy  = 1'b0;
    logic mon_busy   = 1'b0;

    logic [7:0] exp_byte = 8'h00;
    logic       exp_pres = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick generator plus bus model: everything here looks at the edge that just happened.
    initial begin
        bit ticked;
        F1M = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ticked = F1M;
            if (!prev_busy && bus_if.busy) begin
                op_ticks = 0;
                slv_bit  = 0;
                slv_pres = 0;
            end else if (ticked && prev_busy) begin
                op_ticks++;
            end
            if (prev_busy && !bus_if.busy) busy_ticks = op_ticks;
            if (ticked && prev_oe) low_cnt++;
            if (prev_oe && !dq_oe) begin
                low_q.push_back(low_cnt);
                low_cnt = 0;
            end
            if (ticked) slv_cnt++;
            if (!prev_oe && dq_oe && slv_mode == 2) begin
                slv_cnt  = 0;
                slv_pull = ~slv_data[slv_bit % 8];
                slv_bit++;
            end
            if (prev_oe && !dq_oe && slv_mode == 1 && bus_if.busy) begin
                slv_cnt  = 0;
                slv_pres = 1;
            end
            if (slv_mode == 1)
                slv_pull = slv_pres && slv_cnt >= 15 && slv_cnt < 135;
            else if (slv_mode == 0 || slv_cnt >= 40)
                slv_pull = 1'b0;
            prev_oe   = dq_oe;
            prev_busy = bus_if.busy;
            F1M = !ticked && ($urandom_range(0, 1) == 1);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus_if.busy && !mon_busy) eob_cnt = 0;
            if (bus_if.EoB) begin
                eob_cnt++;
                eob_at  = op_ticks + 1;
                eob_f1m = F1M;
            end
            mon_busy = bus_if.busy;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus_if.busy && n < 40000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", bus_if.busy, 1'b0);
    endtask

    task automatic do_op(input logic [1:0] c, input logic [7:0] d, input bit dev, input bit poke);
        int base;
        int exp_w[$];
        int exp_ticks;
        int exp_eob;
        slv_mode = (c == 2'b10) ? 2 : (dev ? 1 : 0);
        slv_data = d;
        base = low_q.size();
        @(negedge clk);
        bus_if.start   = 1'b1;
        bus_if.cmd     = c;
        bus_if.tx_byte = d;
        @(negedge clk);
        bus_if.start   = 1'b0;
        bus_if.tx_byte = 8'($urandom);
        chk("accept", bus_if.busy, 1'b1);
        if (poke) begin
            repeat (50) @(negedge clk);
            bus_if.start   = 1'b1;
            bus_if.cmd     = 2'($urandom_range(0, 2));
            bus_if.tx_byte = 8'($urandom);
            @(negedge clk);
            bus_if.start   = 1'b0;
        end
        wait_idle();
        if (c == 2'b00) begin
            exp_w.push_back(T_RSTL);
            exp_pres  = dev;
            exp_ticks = 2 * T_RSTL;
            exp_eob   = 0;
        end else begin
            for (int i = 0; i < 8; i++)
                exp_w.push_back((c == 2'b01 && !d[i]) ? T_SLOT : T_LOW);
            exp_byte  = d;
            exp_ticks = BYTE_TICKS;
            exp_eob   = 1;
        end
        chk("n_low", low_q.size() - base, exp_w.size());
        for (int i = 0; i < exp_w.size(); i++)
            if (base + i < low_q.size())
                chk($sformatf("low_w%0d", i), low_q[base + i], exp_w[i]);
        chk("byte", bus_if.rx_byte, exp_byte);
        chk("presence", bus_if.presence, exp_pres);
        chk("eob_cnt", eob_cnt, exp_eob);
        chk("busy_ticks", busy_ticks, exp_ticks);
        if (exp_eob == 1) begin
            chk("eob_tick", eob_at, BYTE_TICKS);
            chk("eob_f1m", eob_f1m, 1'b1);
        end
    endtask

    initial begin
        int n;
        int base;
        rst            = 1'b1;
        bus_if.start   = 1'b0;
        bus_if.cmd     = 2'b00;
        bus_if.tx_byte = 8'h00;
        repeat (4) @(negedge clk);
        chk("rst_oe", dq_oe, 1'b0);
        chk("rst_busy", bus_if.busy, 1'b0);
        chk("rst_eob", bus_if.EoB, 1'b0);
        chk("rst_byte", bus_if.rx_byte, 8'h00);
        chk("rst_pres", bus_if.presence, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        do_op(2'b00, 8'h00, 1'b0, 1'b0);
        do_op(2'b00, 8'h00, 1'b1, 1'b0);
        do_op(2'b01, 8'hCC, 1'b0, 1'b0);
        do_op(2'b10, 8'hBE, 1'b0, 1'b1);

        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.cmd   = 2'b11;
        @(negedge clk);
        bus_if.start = 1'b0;
        chk("rsvd_busy", bus_if.busy, 1'b0);
        repeat (20) @(negedge clk);
        chk("rsvd_oe", dq_oe, 1'b0);
        chk("rsvd_byte", bus_if.rx_byte, exp_byte);

        // reset in the middle of bit 3 of an all-zero write
        slv_mode = 0;
        base = low_q.size();
        @(negedge clk);
        bus_if.start   = 1'b1;
        bus_if.cmd     = 2'b01;
        bus_if.tx_byte = 8'h00;
        @(negedge clk);
        bus_if.start = 1'b0;
        n = 0;
        while (!((low_q.size() - base) == 3 && dq_oe) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("bit3_reached", n < 20000, 1'b1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_oe", dq_oe, 1'b0);
        chk("mid_rst_busy", bus_if.busy, 1'b0);
        chk("mid_rst_eob", bus_if.EoB, 1'b0);
        chk("mid_rst_byte", bus_if.rx_byte, 8'h00);
        chk("mid_rst_pres", bus_if.presence, 1'b0);
        @(negedge clk);
        rst      = 1'b0;
        exp_byte = 8'h00;
        exp_pres = 1'b0;
        do_op(2'b00, 8'h00, 1'b1, 1'b0);

        for (int k = 0; k < 8; k++)
            do_op(2'($urandom_range(0, 2)), 8'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));

`ifdef ONEWIRE_STRONG_PULLUP_EN
        do_op(2'b01, 8'h44, 1'b0, 1'b0);
        chk("spu_set", spu, 1'b1);
        repeat (100) @(negedge clk);
        chk("spu_hold", spu, 1'b1);
        chk("spu_oe", dq_oe, 1'b0);
        do_op(2'b10, 8'h5A, 1'b0, 1'b0);
        chk("spu_clr", spu, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
